// File: rtl/sched64_pkg.sv
// Shared definitions for the row scheduler.
// Contents: FSM state codes, the default row-buffer depth, the write-address width,
// the buffer-select constants, and a helper that turns a buffer index into a
// one-hot SRAM write enable.
package sched64_pkg;

    localparam int ROW_WORDS_DEF = 64;
    localparam int WADDR_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FSLD  = 3'd7
    } state_t;

    localparam logic BUF0 = 1'b0;
    localparam logic BUF1 = 1'b1;

    // bit0 -> sram0, bit1 -> sram1; never both
    function automatic logic [1:0] buf_we(input logic sel);
        return (sel == BUF1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/row_sched64_if.sv
// Bundle of the row scheduler's control and data signals.
// slave  : the scheduler side (takes start/cfg_rows/ld_valid/mac_done, drives the rest)
// master : the environment side (DMA, MAC array, layer controller)
// Signals:
//   start, cfg_rows          layer request and row count
//   ld_valid, ld_ready       DMA load-word handshake
//   sram_we, sram_waddr      row-buffer write port (one-hot buffer select)
//   mac_start, mac_buf_sel   MAC array kick-off and source buffer
//   mac_done                 MAC array row completion
//   busy, done, curr_row     layer status
//   outmast_curr_state       raw FSM state
interface row_sched64_if #(
    parameter int ROW_W = 8
);
    import sched64_pkg::*;

    logic               start;
    logic [ROW_W-1:0]   cfg_rows;
    logic               ld_valid;
    logic               ld_ready;
    logic [1:0]         sram_we;
    logic [WADDR_W-1:0] sram_waddr;
    logic               mac_start;
    logic               mac_buf_sel;
    logic               mac_done;
    logic               busy;
    logic               done;
    logic [ROW_W-1:0]   curr_row;
    logic [2:0]         outmast_curr_state;

    modport slave (
        input  start, cfg_rows, ld_valid, mac_done,
        output ld_ready, sram_we, sram_waddr, mac_start, mac_buf_sel,
               busy, done, curr_row, outmast_curr_state
    );

    modport master (
        output start, cfg_rows, ld_valid, mac_done,
        input  ld_ready, sram_we, sram_waddr, mac_start, mac_buf_sel,
               busy, done, curr_row, outmast_curr_state
    );

endinterface

// File: rtl/ld_cnt64.sv
// Load-word counter shared by the first-row fill and the per-row preload.
// Ports:
//   clk, reset  clock, async active-high reset
//   clr         synchronous clear (dominates inc)
//   inc         count one accepted word
//   cnt         current word index, doubles as the SRAM write address
//   tc          high while cnt is on the last word of a row buffer
// The count wraps to 0 after the last word, so a completed row leaves it ready
// for the next fill without an explicit clear.
module ld_cnt64
    import sched64_pkg::*;
#(
    parameter int ROW_WORDS = ROW_WORDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [WADDR_W-1:0] cnt,
    output logic               tc
);

    localparam logic [WADDR_W-1:0] LAST = WADDR_W'(ROW_WORDS - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/row_sched64.sv
// Double-buffered row scheduler for a MAC array.
// A layer is cfg_rows rows. Row 0 is first loaded into sram0 (FSLD); each row is
// then computed by the MAC array from the current buffer while the next row is
// preloaded into the other buffer. The buffers swap each row.
// Ports:
//   clk, reset  clock, async active-high reset
//   bus         row_sched64_if.slave (see interface file for the signal list)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; start with zero rows pulses done and stays
// FSLD   | first fill of the current buffer with ROW_WORDS words
// ISSUE  | one cycle: mac_start on the current buffer, clear preload state
// RUN    | MAC busy on current row; preload next row into the other buffer
// DONE   | one cycle: done pulse, then back to IDLE
module row_sched64
    import sched64_pkg::*;
#(
    parameter int ROW_WORDS = ROW_WORDS_DEF,
    parameter int ROW_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    row_sched64_if.slave  bus
);

    state_t             state;
    logic [ROW_W-1:0]   rows;
    logic [ROW_W-1:0]   row_idx;
    logic               buf_ptr;
    logic               mac_seen;
    logic               pre_full;
    logic               mac_start_r;
    logic               done_r;

    logic [ROW_W-1:0]   rows_m1;
    logic               last_row;
    logic               ld_rdy;
    logic               hs;
    logic               word_last;
    logic               tgt_buf;
    logic               cnt_clr;
    logic               run_exit;
    logic [WADDR_W-1:0] cnt;
    logic               cnt_tc;

    assign rows_m1  = rows - 1'b1;
    assign last_row = (row_idx == rows_m1);

    // The final row has nothing left to preload.
    assign ld_rdy = (state == ST_FSLD) ||
                    ((state == ST_RUN) && (row_idx < rows_m1) && !pre_full);

    assign hs        = bus.ld_valid && ld_rdy;
    assign word_last = hs && cnt_tc;
    assign tgt_buf   = (state == ST_FSLD) ? buf_ptr : ~buf_ptr;
    assign cnt_clr   = (state == ST_IDLE) || (state == ST_ISSUE);

    // mac_done and the last preload word may land in the same cycle; both are
    // looked at combinationally so that case exits immediately.
    assign run_exit = (state == ST_RUN) &&
                      (mac_seen || bus.mac_done) &&
                      (pre_full || word_last || last_row);

    ld_cnt64 #(
        .ROW_WORDS (ROW_WORDS)
    ) u_ld_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (hs),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rows        <= '0;
            row_idx     <= '0;
            buf_ptr     <= BUF0;
            mac_seen    <= 1'b0;
            pre_full    <= 1'b0;
            mac_start_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            mac_start_r <= 1'b0;
            done_r      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_rows != '0) begin
                            rows     <= bus.cfg_rows;
                            row_idx  <= '0;
                            buf_ptr  <= BUF0;
                            mac_seen <= 1'b0;
                            pre_full <= 1'b0;
                            state    <= ST_FSLD;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_FSLD: begin
                    if (word_last) begin
                        mac_start_r <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mac_seen <= 1'b0;
                    pre_full <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.mac_done) begin
                        mac_seen <= 1'b1;
                    end
                    if (word_last) begin
                        pre_full <= 1'b1;
                    end
                    if (run_exit) begin
                        if (last_row) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            buf_ptr     <= ~buf_ptr;
                            row_idx     <= row_idx + 1'b1;
                            mac_start_r <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready           = ld_rdy;
    assign bus.sram_we            = hs ? buf_we(tgt_buf) : 2'b00;
    assign bus.sram_waddr         = cnt;
    assign bus.mac_start          = mac_start_r;
    assign bus.mac_buf_sel        = buf_ptr;
    assign bus.busy               = (state != ST_IDLE);
    assign bus.done               = done_r;
    assign bus.curr_row           = row_idx;
    assign bus.outmast_curr_state = state;

endmodule

// File: tb/tb_row_sched64.sv
module tb_row_sched64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    row_sched64_if #(.ROW_W(8)) bus ();

    row_sched64 #(
        .ROW_WORDS (64),
        .ROW_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        logic [31:0] v;
        v = 32'({bus.outmast_curr_state, bus.busy, bus.ld_ready, bus.sram_we,
                 bus.sram_waddr, bus.mac_start, bus.mac_buf_sel, bus.done, bus.curr_row});
        chk_val(tag, v, 32'd0);
    endtask

    // ---------------- DMA driver ----------------
    logic ld_rand = 1'b0;
    logic ld_hold = 1'b1;
    always @(posedge clk) begin
        #1;
        bus.ld_valid = ld_rand ? 1'($urandom_range(0, 1)) : ld_hold;
    end

    // ---------------- MAC responder ----------------
    logic md_resp   = 1'b0;
    logic md_poke   = 1'b0;
    int   mac_delay = 5;
    assign bus.mac_done = md_resp | md_poke;

    always begin
        @(negedge clk);
        if (bus.mac_start) begin
            repeat (mac_delay) @(posedge clk);
            #1;
            if (!reset) md_resp = 1'b1;
            @(posedge clk);
            #1 md_resp = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int         wr [2];
    logic [5:0] exp_addr [2];
    int         addr_bad = 0;
    int         we_bad   = 0;
    int         n_ms     = 0;
    int         n_done   = 0;
    int         n_busy   = 0;
    int         ms_cyc [64];
    logic       ms_sel [64];
    int         ms_row [64];
    int         md_cyc   = 0;
    int         done_cyc = 0;
    logic       mon_hs;
    int         mon_b;

    initial begin
        wr[0] = 0; wr[1] = 0;
        exp_addr[0] = '0; exp_addr[1] = '0;
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_addr[0] = '0;
            exp_addr[1] = '0;
        end
        mon_hs = bus.ld_valid && bus.ld_ready;
        if (bus.sram_we != 2'b00) begin
            if (!mon_hs || !$onehot(bus.sram_we)) we_bad++;
            mon_b = bus.sram_we[1] ? 1 : 0;
            if (bus.sram_waddr != exp_addr[mon_b]) addr_bad++;
            exp_addr[mon_b] = exp_addr[mon_b] + 6'd1;
            wr[mon_b]++;
        end else if (mon_hs) begin
            we_bad++;
        end
        if (bus.mac_start && n_ms < 64) begin
            ms_cyc[n_ms] = cyc;
            ms_sel[n_ms] = bus.mac_buf_sel;
            ms_row[n_ms] = int'(bus.curr_row);
            n_ms++;
        end
        if (bus.mac_done) md_cyc = cyc;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (bus.busy) n_busy++;
    end

    // ---------------- stimulus helpers ----------------
    int s_cyc = 0;

    task automatic start_layer(input int rows);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.cfg_rows = 8'(rows);
        s_cyc        = cyc;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int i = 0;
        while (n_done == base && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        chk_val(tag, n_done - base, 1);
    endtask

    task automatic wait_ms(input string tag, input int target, input int budget);
        int i = 0;
        while (n_ms < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk_val(tag, (n_ms >= target) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int b_ms, b_done, b_w0, b_w1, b_busy, b_ab, b_wb;
    int exp_sel [3] = '{0, 1, 0};

    initial begin
        bus.start    = 1'b0;
        bus.cfg_rows = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("idle_after_reset");

        // one row, ld_valid held high
        mac_delay = 5;
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        start_layer(1);
        @(negedge clk);
        chk_val("t1_fsld_state", bus.outmast_curr_state, 7);
        chk_val("t1_first_we", bus.sram_we, 1);
        chk_val("t1_first_addr", bus.sram_waddr, 0);
        @(posedge clk); #1 md_poke = 1'b1;
        @(posedge clk); #1 md_poke = 1'b0;
        wait_done("t1_done", b_done, 400);
        chk_val("t1_ms_count", n_ms - b_ms, 1);
        chk_val("t1_ms_latency", ms_cyc[b_ms] - s_cyc, 65);
        chk_val("t1_ms_sel", ms_sel[b_ms], 0);
        chk_val("t1_wr_sram0", wr[0] - b_w0, 64);
        chk_val("t1_wr_sram1", wr[1] - b_w1, 0);
        chk_val("t1_done_lat", done_cyc - md_cyc, 1);
        chk_val("t1_back_idle", bus.outmast_curr_state, 0);
        chk_val("t1_busy_low", bus.busy, 0);

        // three rows, mac_done 10 cycles after each mac_start
        mac_delay = 10;
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        start_layer(3);
        wait_done("t2_done", b_done, 1000);
        chk_val("t2_ms_count", n_ms - b_ms, 3);
        for (int i = 0; i < 3; i++) begin
            chk_val($sformatf("t2_sel%0d", i), ms_sel[b_ms + i], exp_sel[i]);
            chk_val($sformatf("t2_row%0d", i), ms_row[b_ms + i], i);
        end
        chk_val("t2_gap01", ms_cyc[b_ms + 1] - ms_cyc[b_ms], 65);
        chk_val("t2_gap12", ms_cyc[b_ms + 2] - ms_cyc[b_ms + 1], 65);
        chk_val("t2_done_lat", done_cyc - ms_cyc[b_ms + 2], 11);
        chk_val("t2_wr_sram0", wr[0] - b_w0, 128);
        chk_val("t2_wr_sram1", wr[1] - b_w1, 64);
        repeat (5) @(posedge clk);
        chk_val("t2_one_done", n_done - b_done, 1);

        // mac_done coincides with the 64th preload handshake
        mac_delay = 64;
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        start_layer(2);
        wait_done("t3_done", b_done, 1000);
        chk_val("t3_ms_count", n_ms - b_ms, 2);
        chk_val("t3_gap", ms_cyc[b_ms + 1] - ms_cyc[b_ms], 65);
        chk_val("t3_sel1", ms_sel[b_ms + 1], 1);
        chk_val("t3_row1", ms_row[b_ms + 1], 1);
        chk_val("t3_done_lat", done_cyc - ms_cyc[b_ms + 1], 65);
        chk_val("t3_wr_sram1", wr[1] - b_w1, 64);

        // random ld_valid
        mac_delay = 10;
        ld_rand = 1'b1;
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        b_ab = addr_bad; b_wb = we_bad;
        start_layer(2);
        wait_done("t4_done", b_done, 3000);
        ld_rand = 1'b0;
        chk_val("t4_wr_sram0", wr[0] - b_w0, 64);
        chk_val("t4_wr_sram1", wr[1] - b_w1, 64);
        chk_val("t4_wr_total", (wr[0] - b_w0) + (wr[1] - b_w1), 128);
        chk_val("t4_addr_contig", addr_bad - b_ab, 0);
        chk_val("t4_we_only_hs", we_bad - b_wb, 0);
        chk_val("t4_ms_count", n_ms - b_ms, 2);

        // zero rows
        repeat (3) @(posedge clk);
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1]; b_busy = n_busy;
        start_layer(0);
        @(negedge clk);
        chk_val("t5_done_pulse", bus.done, 1);
        chk_val("t5_state_idle", bus.outmast_curr_state, 0);
        @(negedge clk);
        chk_val("t5_done_clear", bus.done, 0);
        repeat (3) @(negedge clk);
        chk_val("t5_busy_never", n_busy - b_busy, 0);
        chk_val("t5_no_writes", (wr[0] - b_w0) + (wr[1] - b_w1), 0);
        chk_val("t5_no_mac", n_ms - b_ms, 0);
        chk_val("t5_done_count", n_done - b_done, 1);

        // start while busy is ignored
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        start_layer(2);
        repeat (10) @(posedge clk);
        start_layer(5);
        wait_ms("t6_first_ms", b_ms + 1, 200);
        repeat (3) @(posedge clk);
        start_layer(7);
        wait_done("t6_done", b_done, 1000);
        chk_val("t6_ms_count", n_ms - b_ms, 2);
        chk_val("t6_row1", ms_row[b_ms + 1], 1);
        chk_val("t6_wr_total", (wr[0] - b_w0) + (wr[1] - b_w1), 128);

        // reset mid-RUN on row 1
        mac_delay = 30;
        b_ms = n_ms; b_done = n_done;
        start_layer(3);
        wait_ms("t7_row1_ms", b_ms + 2, 400);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_val("t7_in_run", bus.outmast_curr_state, 2);
        chk_val("t7_on_row1", bus.curr_row, 1);
        @(posedge clk); #1 reset = 1'b1;
        #2;
        chk_zero("t7_async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("t7_held_reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        chk_val("t7_no_done", n_done - b_done, 0);
        b_ms = n_ms; b_done = n_done; b_w0 = wr[0]; b_w1 = wr[1];
        start_layer(1);
        wait_done("t7_fresh_done", b_done, 600);
        chk_val("t7_fresh_ms", n_ms - b_ms, 1);
        chk_val("t7_fresh_lat", ms_cyc[b_ms] - s_cyc, 65);
        chk_val("t7_fresh_sel", ms_sel[b_ms], 0);
        chk_val("t7_fresh_row", ms_row[b_ms], 0);
        chk_val("t7_fresh_wr0", wr[0] - b_w0, 64);
        chk_val("t7_fresh_wr1", wr[1] - b_w1, 0);

        chk_val("all_addr_contig", addr_bad, 0);
        chk_val("all_we_only_hs", we_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/row_sched64.md
ROW_SCHED64 -- requirements
Module: row_sched64

Interface
REQ-001 The block SHALL have parameter ROW_WORDS, default 64, meaning words loaded per row buffer (legal range 2..64).
REQ-002 The block SHALL have parameter ROW_W, default 8, meaning the width of the row counter and cfg_rows.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-004 Ports SHALL be:
- start: input, 1 bit; one-cycle request to begin a layer.
- cfg_rows: input, ROW_W bits; number of rows, sampled only on an accepted start.
- ld_valid: input, 1 bit; load word offered by the DMA.
- ld_ready: output, 1 bit; the scheduler accepts a load word.
- sram_we: output, 2 bits; one-hot write enable, bit0 selects sram0 and bit1 selects sram1.
- sram_waddr: output, 6 bits; write address within the selected buffer.
- mac_start: output, 1 bit; one-cycle pulse that starts the MAC array on one row.
- mac_buf_sel: output, 1 bit; buffer the MAC array reads from.
- mac_done: input, 1 bit; one-cycle pulse when the MAC array has finished the row.
- busy: output, 1 bit; high while the state is not IDLE.
- done: output, 1 bit; one-cycle pulse at the end of the layer.
- curr_row: output, ROW_W bits; index of the row being computed.
- outmast_curr_state: output, 3 bits; current FSM state.

Function
REQ-005 The FSM states SHALL be encoded IDLE=3'd0, ISSUE=3'd1, RUN=3'd2, DONE=3'd3, FSLD=3'd7; all other codes SHALL go to IDLE on the next cycle.
REQ-006 A word handshake is ld_valid&&ld_ready; each handshake SHALL assert sram_we for the target buffer in the same cycle at address sram_waddr = word count, after which the count increments.
REQ-007 In IDLE, start with cfg_rows!=0 SHALL latch cfg_rows, clear curr_row, word count and buffer pointer (0), and enter FSLD.
REQ-008 In IDLE, start with cfg_rows==0 SHALL pulse done on the next cycle with no loads and no MAC activity, and the FSM SHALL stay in IDLE.
REQ-009 start SHALL be ignored while busy.
REQ-010 In FSLD, ld_ready SHALL be 1 and writes SHALL target the current buffer; the ROW_WORDS-th handshake SHALL move the FSM to ISSUE.
REQ-011 ISSUE SHALL last exactly one cycle, assert mac_start=1 with mac_buf_sel = current buffer, clear the preload count and both flags, then enter RUN.
REQ-012 In RUN, ld_ready SHALL be 1 only while curr_row < rows-1 and the preload is incomplete; preload writes SHALL target the other buffer (!current).
REQ-013 In RUN, registered flags SHALL be kept: mac_seen is set by mac_done; pre_full is set by the ROW_WORDS-th preload handshake.
REQ-014 RUN exit condition: (mac_seen||mac_done) && (pre_full || final preload handshake this cycle || curr_row==rows-1).
REQ-015 On exit with curr_row==rows-1 the FSM SHALL go to DONE; otherwise it SHALL toggle the buffer, increment curr_row and go to ISSUE.
REQ-016 Latency: mac_start SHALL assert exactly one cycle after the cycle in which the exit condition (or the last FSLD word) occurs.
REQ-017 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-018 mac_done outside RUN SHALL be ignored; ld_valid while ld_ready=0 SHALL cause no write and no count change.
REQ-019 sram_we SHALL be 2'b00 whenever there is no handshake; the two bits SHALL never be high together.

Reset
REQ-020 Reset SHALL asynchronously force: state IDLE, ld_ready=0, sram_we=0, sram_waddr=0, mac_start=0, mac_buf_sel=0, busy=0, done=0, curr_row=0, and all counters and flags to 0.
REQ-021 Reset asserted mid-layer SHALL abort the layer with no done pulse; a start after reset deasserts SHALL begin a fresh layer.

Structure
REQ-022 The state codes, ROW_WORDS default and buffer-select constants SHALL live in a shared package, sched64_pkg.
REQ-023 The word counter with its terminal-count flag SHALL be one sub-module, ld_cnt64, instantiated once and reused for both FSLD and preload.

Verification
REQ-024 Bench SHALL cover: cfg_rows=1, ld_valid held 1 -> 64 writes to sram0 at addr 0..63, mac_start at cycle 65, no preload, done one cycle after mac_done.
REQ-025 Bench SHALL cover: cfg_rows=3, mac_done 10 cycles after each mac_start, preload takes 64 cycles -> mac_buf_sel sequence 0,1,0, curr_row 0,1,2, one done pulse.
REQ-026 Bench SHALL cover: mac_done in the same cycle as the 64th preload handshake -> ISSUE on the next cycle, buffer toggled, no lost row.
REQ-027 Bench SHALL cover: ld_valid toggled randomly at 50% -> addresses contiguous, sram_we only on handshakes, total writes = 64*rows.
REQ-028 Bench SHALL cover: start with cfg_rows=0 -> done one cycle later, busy never 1; start while busy -> ignored.
REQ-029 Bench SHALL cover: reset asserted mid-RUN on row 1 -> all outputs zero immediately, no done, next start runs normally.
